dmem_unit: RTL
==============

Name: dmem_unit

Overview:
Data memory stage consumed by the datapath's load/store path: byte-addressed, word-organised RAM of 2^DADDR 32-bit words.
- Decodes RV32I funct3 for LB/LH/LW/LBU/LHU and SB/SH/SW: byte lanes, sign/zero-extension.
- Zero-fills its array after reset via an internal sweep.
- Flags misaligned accesses with a sticky error and captured address.

Parameters:
- WIDTH, 32, data and address width (fixed at 32 for RV32I).
- DADDR, 5, word-address bits; depth = 2^DADDR words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mem_we  input  1  store request this cycle.
- mem_re  input  1  load request this cycle.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  WIDTH  byte address. Bits [DADDR+1:2] = word index, [1:0] = byte offset; upper bits ignored.
- wdata  input  WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
- rdata  output  WIDTH  load result, extended per funct3.
- ready  output  1  high when the clear sweep is done and accesses are accepted.
- misalign  output  1  sticky misaligned-access flag.
- err_addr  output  WIDTH  address of the first misaligned access.

Behaviour:
- Reset (reset_n low, asynchronous): state=CLEAR, sweep counter=0, ready=0, misalign=0, err_addr=0. rdata is combinational and reads 0 while ready=0.
- FSM CLEAR:
  - Each cycle writes 32'h0 to word[counter], then increments the counter.
  - After the write to word 2^DADDR-1, go to RUN. ready=1 from the next cycle.
  - The sweep takes exactly 2^DADDR cycles after reset release.
  - mem_we/mem_re are ignored in CLEAR: no write, no flag update.
- FSM RUN:
  - Stays in RUN until reset.
  - Reset asserted mid-operation forces CLEAR and restarts the sweep from word 0.
- Loads (combinational, zero latency; required by the single-cycle core):
  - B/BU select byte addr[1:0]; H/HU select half addr[1]; W selects the whole word.
  - B and H sign-extend from bit 7/15; BU and HU zero-extend.
  - Reserved funct3 (011, 110, 111) return 0.
  - rdata is valid only when mem_re=1; otherwise it is driven 0.
- Stores:
  - Written on the rising clk edge when mem_we=1 and ready=1.
  - Byte enables: SB enables lane addr[1:0] with wdata[7:0]; SH enables lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW enables all four lanes.
  - Lanes not enabled keep their old value.
  - Reserved funct3 writes nothing.
- Misalignment:
  - Defined as: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, on a cycle where (mem_we|mem_re) and ready.
  - A misaligned store is suppressed: no lanes written.
  - A misaligned load returns 0.
  - On the first misaligned event after reset, misalign=1 and err_addr=addr, both registered (visible the next cycle).
  - Later misaligned events do not overwrite err_addr. misalign clears only on reset.
- Simultaneous mem_we and mem_re on one address: rdata returns the old contents (read-before-write), and the new data is visible the next cycle.
- Address wrap: word index uses only addr[DADDR+1:2], so addr 0x80 aliases word 0 when DADDR=5.
- Contents persist across RUN indefinitely; only reset plus the sweep clears them.

Test Plan:
- Reset, then pre-load garbage via hierarchical force, then release reset -> ready=0 for exactly 32 cycles, then 1; LW at every word returns 0x00000000.
- SW 0x80FF7F01 at 0x10, then LB at 0x10/0x11/0x12/0x13 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU at 0x13 -> 0x00000080; LH at 0x12 -> 0xFFFF80FF; LHU at 0x12 -> 0x000080FF.
- SW 0xAABBCCDD at 0x8, SB 0x11 at 0x9, SH 0x2233 at 0xA -> LW at 0x8 returns 0x223311DD.
- SW 0x12345678 at 0x4, then SH at 0x5 and LW at 0x6 -> misalign=1 the next cycle, err_addr=0x00000005, LW at 0x6 returns 0, word at 0x4 unchanged; a later misaligned LH at 0x7 leaves err_addr=0x5.
- Assert reset_n low for 1 cycle at the 10th cycle of a RUN store stream -> misalign=0, ready=0; a new 32-cycle sweep follows and every word reads 0 afterwards.
- mem_we during CLEAR (cycle 5) of SW 0xDEADBEEF at 0x0 -> ignored; after ready, LW at 0x0 returns 0. SW at 0x84 with DADDR=5 -> LW at 0x04 returns the stored value.

Source files
------------

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressed, word-organised data RAM for an RV32I load/store path.
// After reset the array is cleared by an internal sweep (one word per cycle); accesses are
// accepted only once ready is high. Loads are combinational and stores take effect on the
// rising clock edge.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   mem_we    store request
//   mem_re    load request
//   funct3    RV32I access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr      byte address; word index is addr[DADDR+1:2], byte offset is addr[1:0]
//   wdata     right-justified store data
//   rdata     extended load result (0 when not loading, not ready, misaligned or reserved)
//   ready     clear sweep finished
//   misalign  sticky misaligned-access flag
//   err_addr  address of the first misaligned access
module dmem_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DADDR = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_we,
  input  logic             mem_re,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             misalign,
  output logic [WIDTH-1:0] err_addr
);

  localparam int unsigned Depth = 1 << DADDR;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e           state_q, state_d;
  logic [DADDR-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [Depth];
  logic             misalign_q;
  logic [WIDTH-1:0] err_addr_q;

  logic [DADDR-1:0] widx;
  logic [1:0]       boff;
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             ld_mis, st_mis, mis_evt;
  logic [3:0]       be;
  logic [WIDTH-1:0] wd;
  logic             unused_addr;

  // Upper address bits wrap: only the word index and byte offset matter.
  assign widx        = addr[DADDR+1:2];
  assign boff        = addr[1:0];
  assign unused_addr = ^addr[WIDTH-1:DADDR+2];

  assign ready    = (state_q == StRun);
  assign misalign = misalign_q;
  assign err_addr = err_addr_q;

  // Clear sweep FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Alignment decode; only halfword and word sizes can be misaligned.
  always_comb begin
    ld_mis = 1'b0;
    st_mis = 1'b0;
    case (funct3)
      3'b001: begin
        ld_mis = boff[0];
        st_mis = boff[0];
      end
      3'b101: ld_mis = boff[0];
      3'b010: begin
        ld_mis = |boff;
        st_mis = |boff;
      end
      default: ;
    endcase
  end

  assign mis_evt = ready & ((mem_re & ld_mis) | (mem_we & st_mis));

  // Combinational load path; reads the pre-edge contents, so a same-cycle store is not seen.
  assign rd_word = mem_q[widx];
  assign rd_byte = rd_word[{boff, 3'b000} +: 8];
  assign rd_half = boff[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rdata = '0;
    if (ready && mem_re && !ld_mis) begin
      case (funct3)
        3'b000:  rdata = {{(WIDTH-8){rd_byte[7]}}, rd_byte};
        3'b001:  rdata = {{(WIDTH-16){rd_half[15]}}, rd_half};
        3'b010:  rdata = rd_word;
        3'b100:  rdata = {{(WIDTH-8){1'b0}}, rd_byte};
        3'b101:  rdata = {{(WIDTH-16){1'b0}}, rd_half};
        default: rdata = '0;
      endcase
    end
  end

  // Store lane enables with data replicated across lanes.
  always_comb begin
    be = 4'b0000;
    wd = wdata;
    case (funct3)
      3'b000: begin
        be = 4'b0001 << boff;
        wd = {4{wdata[7:0]}};
      end
      3'b001: begin
        be = boff[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      3'b010: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!ready || !mem_we || st_mis) be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Only the first misaligned event after reset is recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
      err_addr_q <= '0;
    end else if (mis_evt && !misalign_q) begin
      misalign_q <= 1'b1;
      err_addr_q <= addr;
    end
  end

endmodule
